// File: rtl/mat_pkg.sv
// Shared constants and types for the 5x5 matrix multiply / inversion blocks.
package mat_pkg;

  localparam int unsigned MAT_N     = 5;
  localparam int unsigned MAT_DW    = 8;
  localparam int unsigned MAT_ACC_W = 2 * MAT_DW + 3;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    MAC    = 2'd2,
    OUT    = 2'd3
  } mat_state_e;

  typedef logic signed [MAT_DW-1:0]    mat_elem_t;
  typedef logic signed [MAT_ACC_W-1:0] mat_acc_t;

endpackage

// File: rtl/mat_mac_unit.sv
// Signed DW x DW multiply with ACC_W accumulate; registered result.
module mat_mac_unit
  import mat_pkg::*;
#(
  parameter int unsigned DW    = MAT_DW,
  parameter int unsigned ACC_W = MAT_ACC_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [DW-1:0]    i_a,
  input  logic signed [DW-1:0]    i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = i_a * i_b;
  assign o_acc  = r_acc;

  // Accumulator: clear takes priority over enable; product is sign-extended.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential N x N signed matrix multiplier C = A x B with streaming I/O.
module mat_mult_seq
  import mat_pkg::*;
#(
  parameter int unsigned N     = MAT_N,
  parameter int unsigned DW    = MAT_DW,
  parameter int unsigned ACC_W = MAT_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned NN    = N * N;
  localparam int unsigned IDX_W = $clog2(NN);
  localparam int unsigned CNT_W = $clog2(N);

  mat_state_e              r_state;
  logic [IDX_W-1:0]        r_ld_cnt;
  logic [CNT_W-1:0]        r_i, r_j, r_k;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_out_last;
  logic                    r_busy;

  logic signed [DW-1:0]    r_a [NN];
  logic signed [DW-1:0]    r_b [NN];

  logic                    w_accept;
  logic                    w_out_hs;
  logic                    w_is_last;
  logic [IDX_W-1:0]        w_a_idx, w_b_idx;
  logic                    w_mac_clr, w_mac_en;
  logic signed [ACC_W-1:0] w_acc;

  assign w_accept  = in_valid && r_in_ready;
  assign w_out_hs  = (r_state == OUT) && r_out_valid && out_ready;
  assign w_is_last = (r_i == CNT_W'(N - 1)) && (r_j == CNT_W'(N - 1));
  assign w_a_idx   = IDX_W'(r_i) * IDX_W'(N) + IDX_W'(r_k);
  assign w_b_idx   = IDX_W'(r_k) * IDX_W'(N) + IDX_W'(r_j);
  assign w_mac_en  = (r_state == MAC);
  assign w_mac_clr = (r_state == LOAD_A) || (r_state == LOAD_B) || w_out_hs;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  // Operand storage; never reset because every job overwrites it fully.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      if (r_state == LOAD_A) begin
        r_a[r_ld_cnt] <= in_data;
      end else begin
        r_b[r_ld_cnt] <= in_data;
      end
    end
  end

  mat_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (r_a[w_a_idx]),
    .i_b   (r_b[w_b_idx]),
    .o_acc (w_acc)
  );

  // Control FSM: load A, load B, then N-cycle MAC and output per element.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD_A;
      r_ld_cnt    <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_busy <= 1'b1;
            if (r_ld_cnt == IDX_W'(NN - 1)) begin
              r_ld_cnt <= '0;
              r_state  <= LOAD_B;
            end else begin
              r_ld_cnt <= r_ld_cnt + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_accept) begin
            if (r_ld_cnt == IDX_W'(NN - 1)) begin
              r_ld_cnt   <= '0;
              r_i        <= '0;
              r_j        <= '0;
              r_k        <= '0;
              r_in_ready <= 1'b0;
              r_state    <= MAC;
            end else begin
              r_ld_cnt <= r_ld_cnt + IDX_W'(1);
            end
          end
        end
        MAC: begin
          if (r_k == CNT_W'(N - 1)) begin
            r_k     <= '0;
            r_state <= OUT;
          end else begin
            r_k <= r_k + CNT_W'(1);
          end
        end
        OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc;
            r_out_last  <= w_is_last;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_is_last) begin
              r_i        <= '0;
              r_j        <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= LOAD_A;
            end else begin
              if (r_j == CNT_W'(N - 1)) begin
                r_j <= '0;
                r_i <= r_i + CNT_W'(1);
              end else begin
                r_j <= r_j + CNT_W'(1);
              end
              r_state <= MAC;
            end
          end
        end
        default: begin
          r_state     <= LOAD_A;
          r_ld_cnt    <= '0;
          r_i         <= '0;
          r_j         <= '0;
          r_k         <= '0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed self-checking bench for mat_mult_seq (5x5, DW=8, ACC_W=19).
module tb_mat_mult_seq;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [18:0] out_data;
  logic               out_last;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int first_hs = 0;
  int last_hs  = 0;

  logic signed [7:0] ta    [25];
  logic signed [7:0] tbm   [25];
  int                exp_c [25];

  mat_mult_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand set 1: A = identity, B[r][c] = 5r+c, so C = B.
  task automatic set_identity_job();
    for (int n = 0; n < 25; n++) begin
      ta[n]    = ((n / 5) == (n % 5)) ? 8'sd1 : 8'sd0;
      tbm[n]   = 8'(n);
      exp_c[n] = n;
    end
  endtask

  // Constant-filled operands with a hand-computed constant result.
  task automatic set_const_job(input logic signed [7:0] av, input logic signed [7:0] bv, input int cv);
    for (int n = 0; n < 25; n++) begin
      ta[n]    = av;
      tbm[n]   = bv;
      exp_c[n] = cv;
    end
  endtask

  // Stream the first 'count' elements of A then B; optional idle cycle after each.
  task automatic load_job(input int count, input bit gap, input bit hold);
    int g;
    for (int e = 0; e < count; e++) begin
      in_valid = 1'b1;
      in_data  = (e < 25) ? ta[e] : tbm[e - 25];
      g = 0;
      while (!in_ready && g < 20) begin
        @(posedge clk); #1; g++;
      end
      if (!in_ready) begin
        n_checks++;
        $display("FAIL load_wait elem %0d: in_ready=0 after %0d cycles, required 1", e, g);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (e == 0) first_hs = cyc;
      last_hs = cyc;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (hold) begin
      in_valid = 1'b1;
      in_data  = 8'sh5A;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Drain all 25 results in order, checking value, last flag, latency and stalls.
  task automatic drain(input string tag, input int stall_idx, input int stall_len, input bit hold);
    int g;
    int ref_c;
    logic signed [18:0] e19;
    logic el;
    ref_c = last_hs;
    for (int n = 0; n < 25; n++) begin
      e19 = 19'(exp_c[n]);
      el  = (n == 24);
      g = 0;
      while (!out_valid && g < 40) begin
        @(posedge clk); #1; g++;
      end
      n_checks++;
      if (!out_valid) begin
        $display("FAIL %s wait_C%0d: out_valid=0 after %0d cycles, required 1", tag, n, g);
        return;
      end else n_pass++;
      n_checks++;
      if ((cyc - ref_c) !== 6) $display("FAIL %s latency_C%0d: got %0d cycles, required 6", tag, n, cyc - ref_c);
      else n_pass++;
      n_checks++;
      if (out_data !== e19) $display("FAIL %s data_C%0d: got %0d, required %0d", tag, n, out_data, e19);
      else n_pass++;
      n_checks++;
      if (out_last !== el) $display("FAIL %s last_C%0d: got %0b, required %0b", tag, n, out_last, el);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL %s in_ready_C%0d: got %0b, required 0", tag, n, in_ready);
      else n_pass++;
      if (n == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== e19 || out_last !== el || in_ready !== 1'b0)
            $display("FAIL %s stall_C%0d cyc %0d: valid=%0b data=%0d last=%0b in_ready=%0b, required 1/%0d/%0b/0",
                     tag, n, s, out_valid, out_data, out_last, in_ready, e19, el);
          else n_pass++;
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      ref_c = cyc;
      out_ready = 1'b0;
      if (el) in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL %s drop_C%0d: out_valid=%0b after handshake, required 0", tag, n, out_valid);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s idle_after: busy=%0b in_ready=%0b, required 0/1", tag, busy, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 19'sd0 || out_last !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_data=%0d out_last=%0b busy=%0b, required all 0",
               in_ready, out_valid, out_data, out_last, busy);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1/0", in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_identity();
    set_identity_job();
    load_job(50, 1'b0, 1'b0);
    drain("identity", -1, 0, 1'b0);
  endtask

  task automatic test_neg_neg();
    set_const_job(-8'sd128, -8'sd128, 81920);
    load_job(50, 1'b0, 1'b0);
    drain("neg_neg", -1, 0, 1'b0);
  endtask

  task automatic test_pos_neg();
    set_const_job(8'sd127, -8'sd128, -81280);
    load_job(50, 1'b0, 1'b0);
    drain("pos_neg", -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    set_identity_job();
    load_job(50, 1'b0, 1'b0);
    drain("stall", 2, 10, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_const_job(8'sd3, -8'sd7, 0);
    load_job(30, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid: in_ready=%0b out_valid=%0b busy=%0b, required 1/0/0", in_ready, out_valid, busy);
    else n_pass++;
    set_identity_job();
    load_job(50, 1'b0, 1'b0);
    drain("reset_mid", -1, 0, 1'b0);
  endtask

  task automatic test_gap_hold();
    set_identity_job();
    load_job(50, 1'b1, 1'b1);
    n_checks++;
    if ((last_hs - first_hs) !== 98)
      $display("FAIL gap_load_span: first-to-last accept %0d cycles, required 98", last_hs - first_hs);
    else n_pass++;
    drain("gap_hold", -1, 0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_identity();
    test_neg_neg();
    test_pos_neg();
    test_stall();
    test_reset_mid();
    test_gap_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mat_mult_seq.md
Name: mat_mult_seq

Overview:
- Sequential 5x5 signed matrix multiplier computing C = A x B. It is the forward-direction counterpart of the augmented-matrix inversion block.
- Used to multiply a matrix by its computed inverse, to check for identity, and to apply an inverse to data.
- Operands stream in element-by-element over a valid/ready input. Products stream out element-by-element over a valid/ready output.

Parameters:
N, 5, matrix dimension (square)
DW, 8, operand element width, signed two's complement
ACC_W, 2*DW+3, result width; for N=5 a full sum of N products cannot overflow

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  in_data holds a valid operand element
in_ready  out  1  block accepts an element this cycle
in_data  in  DW  operand element, signed
out_valid  out  1  out_data holds a valid result element
out_ready  in  1  downstream accepts the result this cycle
out_data  out  ACC_W  result element C[i][j], signed
out_last  out  1  high with out_valid on C[N-1][N-1]
busy  out  1  high in every state except LOAD_A when zero elements have been accepted

Behaviour:
- Reset: while rst is high, all of the following hold at the next edge.
  - FSM goes to LOAD_A; all counters are 0.
  - in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0.
  - Operand arrays are not cleared; they are fully overwritten before use.
- Reset mid-operation abandons the current job with no partial output. The first element after reset is A[0][0].
- Input handshake: an element is accepted on an edge where in_valid && in_ready.
  - in_ready = 1 exactly in LOAD_A and LOAD_B; this is a registered state decode.
  - in_valid outside those states is ignored.
- Load order:
  - LOAD_A takes N*N elements, row-major, into A[r][c].
  - LOAD_B then takes N*N elements, row-major, into B[r][c].
  - The FSM moves LOAD_A->LOAD_B on A element N*N-1, and LOAD_B->MAC on B element N*N-1.
  - Gaps in in_valid simply stall the load counter.
- MAC state, for output index (i,j):
  - Runs exactly N cycles, k=0..N-1, each doing acc += A[i][k]*B[k][j].
  - Products are full 2*DW signed; the accumulator is ACC_W signed.
  - acc is cleared on MAC entry. No saturation or truncation.
  - Then the FSM goes to OUT.
- OUT state:
  - out_valid=1, out_data=acc, out_last=(i==N-1 && j==N-1).
  - All three outputs stay stable until out_ready is sampled high.
  - On handshake: j increments; on wrap, j=0 and i increments. The FSM goes to MAC for the next element.
  - On the last element, the FSM goes to LOAD_A instead and clears all counters.
- Output order is row-major C[0][0]..C[N-1][N-1].
- Latency:
  - First out_valid rises N+1 cycles after the edge accepting B[N-1][N-1].
  - Each subsequent out_valid rises N+1 cycles after the previous output handshake.
- out_valid falls in the cycle after its handshake. It never asserts outside OUT.
- in_ready is 0 from MAC entry until return to LOAD_A. A new job cannot overlap with draining.
- States: LOAD_A, LOAD_B, MAC, OUT. Any illegal encoding goes to LOAD_A.

Decomposition:
- Shared package mat_pkg holds:
  - constants MAT_N=5, MAT_DW=8, MAT_ACC_W;
  - state enum {LOAD_A, LOAD_B, MAC, OUT};
  - element and accumulator typedefs.
  - The inversion block reuses the N/DW constants.
- One sub-module: mat_mac_unit.
  - Signed DW x DW multiply plus ACC_W accumulate, with clear and enable inputs.
  - One-cycle update, result registered.

Test Plan:
- A=identity, B[r][c]=5r+c -> out_data sequence 0,1,...,24; out_last only on the 25th; first out_valid exactly 6 cycles after the last input handshake.
- All A=-128, all B=-128 -> every out_data = 81920 (0x14000). Confirms no overflow at the ACC_W boundary.
- All A=127, all B=-128 -> every out_data = -81280.
- Hold out_ready=0 for 10 cycles on C[0][2] -> out_valid, out_data and out_last stay constant; in_ready=0 throughout; all 25 results are still correct and in order.
- Assert rst for 1 cycle after 30 elements are accepted -> next cycle in_ready=1, out_valid=0, busy=0. A fresh identity x B load then yields the exact case-1 results with no residue.
- in_valid toggled every other cycle, plus in_valid held high during MAC/OUT -> results identical to case 1; no extra elements accepted; load takes 100 cycles.
